// File: rtl/reg_value_display.sv
// Display stage: converts an 8-bit register value to decimal by sequential
// shift-add-3 and drives four active-low abcdefg digits. Option: SIGNED_DISPLAY_EN.
module reg_value_display #(
    parameter int unsigned VALUE_W     = 8,
    parameter int unsigned CONV_CYCLES = 8
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic [1:7]         leds3,
    output logic [1:7]         leds2,
    output logic [1:7]         leds1,
    output logic [1:7]         leds0
);

    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);
    localparam logic [1:7]  SEG_BLANK = 7'b1111111;
`ifdef SIGNED_DISPLAY_EN
    localparam logic [1:7]  SEG_MINUS = 7'b1111110;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_e;

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] shift_q, shift_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [1:7]         leds3_q, leds3_d;
    logic [1:7]         leds2_q, leds2_d;
    logic [1:7]         leds1_q, leds1_d;
    logic [1:7]         leds0_q, leds0_d;
    logic [VALUE_W-1:0] mag;
    logic [11:0]        bcd_adj;
`ifdef SIGNED_DISPLAY_EN
    logic               sign_q, sign_d;
`endif

    function automatic logic [1:7] seg7(input logic [3:0] n);
        logic [1:7] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef SIGNED_DISPLAY_EN
    assign mag = value[VALUE_W-1] ? (~value + VALUE_W'(1)) : value;
`else
    assign mag = value;
`endif

    assign bcd_adj = add3(bcd_q);

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            leds3_q <= SEG_BLANK;
            leds2_q <= SEG_BLANK;
            leds1_q <= SEG_BLANK;
            leds0_q <= SEG_BLANK;
`ifdef SIGNED_DISPLAY_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            leds3_q <= leds3_d;
            leds2_q <= leds2_d;
            leds1_q <= leds1_d;
            leds0_q <= leds0_d;
`ifdef SIGNED_DISPLAY_EN
            sign_q  <= sign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(CONV_CYCLES - 1)) state_d = ENCODE;
            ENCODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        leds3_d = leds3_q;
        leds2_d = leds2_q;
        leds1_d = leds1_q;
        leds0_d = leds0_q;
`ifdef SIGNED_DISPLAY_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
`ifdef SIGNED_DISPLAY_EN
                    sign_d  = value[VALUE_W-1];
`endif
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d            = cnt_q + CNT_W'(1);
            end
            ENCODE: begin
                // Leading zeros blank; units digit is always shown.
                leds2_d = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
                leds1_d = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
                leds0_d = seg7(bcd_q[3:0]);
`ifdef SIGNED_DISPLAY_EN
                leds3_d = sign_q ? SEG_MINUS : SEG_BLANK;
`else
                leds3_d = SEG_BLANK;
`endif
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state_q == SHIFT) || (state_q == ENCODE);
        done  = done_q;
        leds3 = leds3_q;
        leds2 = leds2_q;
        leds1 = leds1_q;
        leds0 = leds0_q;
    end

endmodule

// File: tb/tb_reg_value_display.sv
// Directed self-checking bench for reg_value_display (both SIGNED_DISPLAY_EN builds).
module tb_reg_value_display;

    logic       clock;
    logic       resetN;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [1:7] leds3, leds2, leds1, leds0;

    int total = 0;
    int bad   = 0;
    int done_cnt;
    logic [6:0] p3, p2, p1, p0;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b1111110;
    localparam logic [6:0] D0 = 7'b0000001;
    localparam logic [6:0] D1 = 7'b1001111;
    localparam logic [6:0] D2 = 7'b0010010;
    localparam logic [6:0] D4 = 7'b1001100;
    localparam logic [6:0] D5 = 7'b0100100;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0000100;

    reg_value_display #(.VALUE_W(8), .CONV_CYCLES(8)) dut (
        .clock (clock),
        .resetN(resetN),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .leds3 (leds3),
        .leds2 (leds2),
        .leds1 (leds1),
        .leds0 (leds0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_leds(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, ".leds3"}, 32'(leds3), 32'(e3));
        chk({tag, ".leds2"}, 32'(leds2), 32'(e2));
        chk({tag, ".leds1"}, 32'(leds1), 32'(e1));
        chk({tag, ".leds0"}, 32'(leds0), 32'(e0));
    endtask

    // Called at a negedge; leaves the bench at a negedge one cycle after done.
    task automatic run_conv(input string tag, input logic [7:0] v, input logic [6:0] e3,
                            input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        value = v;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        value = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".done_early"}, 32'(done), 32'd0);
            if (i == 4) chk_leds({tag, ".hold"}, p3, p2, p1, p0);
            @(negedge clock);
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk_leds(tag, e3, e2, e1, e0);
        p3 = e3; p2 = e2; p1 = e1; p0 = e0;
        @(negedge clock);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        resetN = 1'b0;
        start  = 1'b1;
        value  = 8'd77;
        p3 = BL; p2 = BL; p1 = BL; p0 = BL;
        repeat (3) @(negedge clock);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_leds("reset", BL, BL, BL, BL);
        start  = 1'b0;
        resetN = 1'b1;
        @(negedge clock);
        chk("idle.busy", 32'(busy), 32'd0);

        run_conv("v0", 8'd0, BL, BL, BL, D0);
`ifdef SIGNED_DISPLAY_EN
        run_conv("v255", 8'd255, MI, BL, BL, D1);
`else
        run_conv("v255", 8'd255, BL, D2, D5, D5);
`endif
        run_conv("v105", 8'd105, BL, D1, D0, D5);

        // Second start at E+3 must be ignored; value change after capture ignored.
        value    = 8'd42;
        start    = 1'b1;
        done_cnt = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            start = (n == 3);
            if (n == 3) value = 8'd7;
            if (done) done_cnt++;
            if (n == 9)  chk("v42.busy_e8", 32'(busy), 32'd1);
            if (n == 10) begin
                chk("v42.done", 32'(done), 32'd1);
                chk("v42.busy_e9", 32'(busy), 32'd0);
                chk_leds("v42", BL, BL, D4, D2);
            end
        end
        chk("v42.done_count", 32'(done_cnt), 32'd1);
        chk("v42.busy_after", 32'(busy), 32'd0);
        p3 = BL; p2 = BL; p1 = D4; p0 = D2;

        // Reset at E+4 aborts the conversion.
        value = 8'd200;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort.busy_pre", 32'(busy), 32'd1);
        resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_leds("abort", BL, BL, BL, BL);
        done_cnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        chk("abort.no_done", 32'(done_cnt), 32'd0);
        p3 = BL; p2 = BL; p1 = BL; p0 = BL;

        run_conv("v9", 8'd9, BL, BL, BL, D9);

        // Continuous start: accepted every 10 cycles.
        value = 8'd3;
        start = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clock);
            if (n == 10 || n == 20) chk($sformatf("cont.done%0d", n), 32'(done), 32'd1);
            if (n == 9  || n == 11) chk($sformatf("cont.nodone%0d", n), 32'(done), 32'd0);
            if (n == 10) chk("cont.busy10", 32'(busy), 32'd0);
            if (n == 11) chk("cont.busy11", 32'(busy), 32'd1);
        end
        start = 1'b0;
        repeat (12) @(negedge clock);
        chk_leds("cont", BL, BL, BL, 7'b0000110);
        p3 = BL; p2 = BL; p1 = BL; p0 = 7'b0000110;

`ifdef SIGNED_DISPLAY_EN
        run_conv("s80", 8'h80, MI, D1, D2, D8);
        run_conv("s7f", 8'h7F, BL, D1, D2, 7'b0001111);
`else
        run_conv("u80", 8'h80, BL, D1, D2, D8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
